// File: rtl/xif_core_offload_ctrl.sv
// ----------------------------------------------------------------------------
// xif_core_offload_ctrl
//
// Core-side (initiator) end of the CORE-V eXtension interface. Instructions
// the CPU decoder flags as offloadable are issued to the coprocessor, then
// committed (or killed) one cycle after the issue handshake. Every accepted
// offload holds a scoreboard bit until its result retires into the CPU
// register-file write port. Coprocessor memory requests are served over a
// single-outstanding OBI data port.
//
// Ports
//   clk_i, rst_ni                  clock, asynchronous active-low reset
//   off_*                          core offload request and issue response
//   flush_i                        core kill, sampled in the issue handshake
//   busy_o                         offloads outstanding or issue pending
//   x_issue_*                      XIF issue channel (initiator side)
//   x_commit_*                     XIF commit channel
//   x_mem_*                        XIF memory request channel (target side)
//   x_mem_result_*                 XIF memory result channel
//   data_*                         OBI data port (single outstanding)
//   x_result_*                     XIF result channel (target side)
//   rf_wport_free_i, rf_*          CPU register-file write port
//   spurious_result_o              pulse: result ID not outstanding
// ----------------------------------------------------------------------------
module xif_core_offload_ctrl #(
   parameter int X_ID_WIDTH      = 4,
   parameter int MAX_OUTSTANDING = 4,
   parameter int XLEN            = 32
) (
   input  logic                  clk_i,
   input  logic                  rst_ni,

   input  logic                  off_valid_i,
   output logic                  off_ready_o,
   input  logic [31:0]           off_instr_i,
   input  logic [XLEN-1:0]       off_rs1_i,
   input  logic [XLEN-1:0]       off_rs2_i,
   output logic                  off_resp_valid_o,
   output logic                  off_resp_accept_o,
   output logic                  off_resp_writeback_o,
   input  logic                  flush_i,
   output logic                  busy_o,

   output logic                  x_issue_valid_o,
   input  logic                  x_issue_ready_i,
   output logic [31:0]           x_issue_instr_o,
   output logic [X_ID_WIDTH-1:0] x_issue_id_o,
   output logic [2*XLEN-1:0]     x_issue_rs_o,
   output logic [1:0]            x_issue_rs_valid_o,
   input  logic                  x_issue_resp_accept_i,
   input  logic                  x_issue_resp_writeback_i,

   output logic                  x_commit_valid_o,
   output logic [X_ID_WIDTH-1:0] x_commit_id_o,
   output logic                  x_commit_kill_o,

   input  logic                  x_mem_valid_i,
   output logic                  x_mem_ready_o,
   input  logic [X_ID_WIDTH-1:0] x_mem_id_i,
   input  logic [31:0]           x_mem_addr_i,
   input  logic                  x_mem_we_i,
   input  logic [3:0]            x_mem_be_i,
   input  logic [XLEN-1:0]       x_mem_wdata_i,
   output logic                  x_mem_result_valid_o,
   output logic [X_ID_WIDTH-1:0] x_mem_result_id_o,
   output logic [XLEN-1:0]       x_mem_result_rdata_o,

   output logic                  data_req_o,
   input  logic                  data_gnt_i,
   output logic [31:0]           data_addr_o,
   output logic                  data_we_o,
   output logic [3:0]            data_be_o,
   output logic [XLEN-1:0]       data_wdata_o,
   input  logic                  data_rvalid_i,
   input  logic [XLEN-1:0]       data_rdata_i,

   input  logic                  x_result_valid_i,
   output logic                  x_result_ready_o,
   input  logic [X_ID_WIDTH-1:0] x_result_id_i,
   input  logic [4:0]            x_result_rd_i,
   input  logic                  x_result_we_i,
   input  logic [XLEN-1:0]       x_result_data_i,

   input  logic                  rf_wport_free_i,
   output logic                  rf_we_o,
   output logic [4:0]            rf_waddr_o,
   output logic [XLEN-1:0]       rf_wdata_o,
   output logic                  spurious_result_o
);

   localparam int SB_DEPTH = 1 << X_ID_WIDTH;
   localparam int CNT_W    = $clog2(MAX_OUTSTANDING + 1);

   localparam logic [CNT_W-1:0]      CNT_ONE = CNT_W'(1);
   localparam logic [CNT_W-1:0]      CNT_MAX = CNT_W'(MAX_OUTSTANDING);
   localparam logic [X_ID_WIDTH-1:0] ID_ONE  = X_ID_WIDTH'(1);

   typedef enum logic {
      ISS_IDLE,
      ISS_ISSUE
   } iss_state_t;

   typedef enum logic [1:0] {
      MEM_IDLE,
      MEM_REQ,
      MEM_WAIT,
      MEM_RESP
   } mem_state_t;

   // IDs wrap modulo 2^X_ID_WIDTH
   function automatic logic [X_ID_WIDTH-1:0] id_inc(input logic [X_ID_WIDTH-1:0] id);
      return id + ID_ONE;
   endfunction

   iss_state_t             iss_state_q, iss_state_d;
   mem_state_t             mem_state_q, mem_state_d;

   logic [X_ID_WIDTH-1:0]  next_id_q;
   logic [CNT_W-1:0]       cnt_q, cnt_d;
   logic [SB_DEPTH-1:0]    sb_q, sb_d;

   logic [31:0]            iss_instr_p0;
   logic [XLEN-1:0]        iss_rs1_p0;
   logic [XLEN-1:0]        iss_rs2_p0;
   logic [X_ID_WIDTH-1:0]  iss_id_p0;

   logic                   cmt_vld_p1;
   logic [X_ID_WIDTH-1:0]  cmt_id_p1;
   logic                   cmt_kill_p1;
   logic                   cmt_acc_p1;
   logic                   resp_acc_p1;
   logic                   resp_wb_p1;

   logic [31:0]            mem_addr_q;
   logic                   mem_we_q;
   logic [3:0]             mem_be_q;
   logic [XLEN-1:0]        mem_wdata_q;
   logic [X_ID_WIDTH-1:0]  mem_id_q;
   logic [XLEN-1:0]        mem_rdata_q;

   logic                   off_hs;
   logic                   iss_hs;
   logic                   iss_inc;
   logic                   kill_dec;
   logic                   res_hs;
   logic                   res_hit;
   logic                   mem_hs;

   assign off_hs   = off_valid_i && off_ready_o;
   assign iss_hs   = x_issue_valid_o && x_issue_ready_i;
   assign iss_inc  = iss_hs && x_issue_resp_accept_i;
   assign kill_dec = cmt_vld_p1 && cmt_kill_p1 && cmt_acc_p1;
   assign res_hs   = x_result_valid_i && x_result_ready_o;
   assign mem_hs   = x_mem_valid_i && x_mem_ready_o;

   // A result for an ID being killed this very cycle counts as spurious, so
   // the same scoreboard entry is never released twice.
   assign res_hit  = res_hs && sb_q[x_result_id_i] &&
                     !(kill_dec && (cmt_id_p1 == x_result_id_i));

   // ------------------------------------------------------------------------
   // Issue FSM: state register
   // ------------------------------------------------------------------------
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         iss_state_q <= ISS_IDLE;
      end else begin
         iss_state_q <= iss_state_d;
      end
   end

   // Issue FSM: next state
   always_comb begin
      iss_state_d = iss_state_q;
      case (iss_state_q)
         ISS_IDLE:  if (off_hs)          iss_state_d = ISS_ISSUE;
         ISS_ISSUE: if (x_issue_ready_i) iss_state_d = ISS_IDLE;
         default:                        iss_state_d = ISS_IDLE;
      endcase
   end

   // Issue FSM: outputs. Ready-type outputs are gated by rst_ni so that every
   // output is low while reset is held.
   always_comb begin
      off_ready_o        = rst_ni && (iss_state_q == ISS_IDLE) &&
                           (cnt_q < CNT_MAX) && !sb_q[next_id_q];
      x_issue_valid_o    = (iss_state_q == ISS_ISSUE);
      x_issue_rs_valid_o = {2{x_issue_valid_o}};
      busy_o             = (cnt_q != '0) || (iss_state_q == ISS_ISSUE);
   end

   assign x_issue_instr_o      = iss_instr_p0;
   assign x_issue_id_o         = iss_id_p0;
   assign x_issue_rs_o         = {iss_rs2_p0, iss_rs1_p0};

   assign x_commit_valid_o     = cmt_vld_p1;
   assign x_commit_id_o        = cmt_id_p1;
   assign x_commit_kill_o      = cmt_kill_p1;
   assign off_resp_valid_o     = cmt_vld_p1;
   assign off_resp_accept_o    = resp_acc_p1;
   assign off_resp_writeback_o = resp_wb_p1;

   // Scoreboard and outstanding count: issue, kill and result may all land in
   // the same cycle, each contributing its own +1/-1.
   always_comb begin
      sb_d  = sb_q;
      cnt_d = cnt_q;
      if (kill_dec) begin
         sb_d[cmt_id_p1] = 1'b0;
         cnt_d           = cnt_d - CNT_ONE;
      end
      if (res_hit) begin
         sb_d[x_result_id_i] = 1'b0;
         cnt_d               = cnt_d - CNT_ONE;
      end
      if (iss_inc) begin
         sb_d[iss_id_p0] = 1'b1;
         cnt_d           = cnt_d + CNT_ONE;
      end
   end

   // ------------------------------------------------------------------------
   // Stage p0: offload handshake latches the issue payload.
   // Stage p1: issue handshake produces commit and issue response.
   // ------------------------------------------------------------------------
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         iss_instr_p0 <= '0;
         iss_rs1_p0   <= '0;
         iss_rs2_p0   <= '0;
         iss_id_p0    <= '0;
         cmt_vld_p1   <= 1'b0;
         cmt_id_p1    <= '0;
         cmt_kill_p1  <= 1'b0;
         cmt_acc_p1   <= 1'b0;
         resp_acc_p1  <= 1'b0;
         resp_wb_p1   <= 1'b0;
         next_id_q    <= '0;
         sb_q         <= '0;
         cnt_q        <= '0;
      end else begin
         if (off_hs) begin
            iss_instr_p0 <= off_instr_i;
            iss_rs1_p0   <= off_rs1_i;
            iss_rs2_p0   <= off_rs2_i;
            iss_id_p0    <= next_id_q;
         end
         cmt_vld_p1 <= iss_hs;
         if (iss_hs) begin
            cmt_id_p1   <= iss_id_p0;
            cmt_kill_p1 <= flush_i;
            cmt_acc_p1  <= x_issue_resp_accept_i;
            resp_acc_p1 <= x_issue_resp_accept_i;
            resp_wb_p1  <= x_issue_resp_writeback_i;
            next_id_q   <= id_inc(next_id_q);
         end
         sb_q  <= sb_d;
         cnt_q <= cnt_d;
      end
   end

   // Result retirement is combinational into the register-file port.
   assign x_result_ready_o  = rst_ni && rf_wport_free_i;
   assign spurious_result_o = res_hs && !res_hit;
   assign rf_we_o           = res_hit && x_result_we_i;
   assign rf_waddr_o        = rf_we_o ? x_result_rd_i : 5'd0;
   assign rf_wdata_o        = rf_we_o ? x_result_data_i : '0;

   // ------------------------------------------------------------------------
   // Mem FSM: state register
   // ------------------------------------------------------------------------
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         mem_state_q <= MEM_IDLE;
      end else begin
         mem_state_q <= mem_state_d;
      end
   end

   // Mem FSM: next state
   always_comb begin
      mem_state_d = mem_state_q;
      case (mem_state_q)
         MEM_IDLE: if (mem_hs)        mem_state_d = MEM_REQ;
         MEM_REQ:  if (data_gnt_i)    mem_state_d = MEM_WAIT;
         MEM_WAIT: if (data_rvalid_i) mem_state_d = MEM_RESP;
         MEM_RESP:                    mem_state_d = MEM_IDLE;
         default:                     mem_state_d = MEM_IDLE;
      endcase
   end

   // Mem FSM: outputs
   always_comb begin
      x_mem_ready_o        = rst_ni && (mem_state_q == MEM_IDLE);
      data_req_o           = (mem_state_q == MEM_REQ);
      x_mem_result_valid_o = (mem_state_q == MEM_RESP);
   end

   assign data_addr_o          = mem_addr_q;
   assign data_we_o            = mem_we_q;
   assign data_be_o            = mem_be_q;
   assign data_wdata_o         = mem_wdata_q;
   assign x_mem_result_id_o    = mem_id_q;
   assign x_mem_result_rdata_o = mem_rdata_q;

   // Mem request payload and returned read data (returned for stores too)
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         mem_addr_q  <= '0;
         mem_we_q    <= 1'b0;
         mem_be_q    <= '0;
         mem_wdata_q <= '0;
         mem_id_q    <= '0;
         mem_rdata_q <= '0;
      end else begin
         if (mem_hs) begin
            mem_addr_q  <= x_mem_addr_i;
            mem_we_q    <= x_mem_we_i;
            mem_be_q    <= x_mem_be_i;
            mem_wdata_q <= x_mem_wdata_i;
            mem_id_q    <= x_mem_id_i;
         end
         if ((mem_state_q == MEM_WAIT) && data_rvalid_i) begin
            mem_rdata_q <= data_rdata_i;
         end
      end
   end

endmodule

// File: tb/tb_xif_core_offload_ctrl.sv
module tb_xif_core_offload_ctrl;

   localparam int IDW  = 4;
   localparam int MAXO = 4;
   localparam int XL   = 32;

   logic            clk_i = 1'b0;
   logic            rst_ni = 1'b0;
   logic            off_valid_i, off_ready_o;
   logic [31:0]     off_instr_i;
   logic [XL-1:0]   off_rs1_i, off_rs2_i;
   logic            off_resp_valid_o, off_resp_accept_o, off_resp_writeback_o;
   logic            flush_i, busy_o;
   logic            x_issue_valid_o, x_issue_ready_i;
   logic [31:0]     x_issue_instr_o;
   logic [IDW-1:0]  x_issue_id_o;
   logic [2*XL-1:0] x_issue_rs_o;
   logic [1:0]      x_issue_rs_valid_o;
   logic            x_issue_resp_accept_i, x_issue_resp_writeback_i;
   logic            x_commit_valid_o;
   logic [IDW-1:0]  x_commit_id_o;
   logic            x_commit_kill_o;
   logic            x_mem_valid_i, x_mem_ready_o;
   logic [IDW-1:0]  x_mem_id_i;
   logic [31:0]     x_mem_addr_i;
   logic            x_mem_we_i;
   logic [3:0]      x_mem_be_i;
   logic [XL-1:0]   x_mem_wdata_i;
   logic            x_mem_result_valid_o;
   logic [IDW-1:0]  x_mem_result_id_o;
   logic [XL-1:0]   x_mem_result_rdata_o;
   logic            data_req_o, data_gnt_i;
   logic [31:0]     data_addr_o;
   logic            data_we_o;
   logic [3:0]      data_be_o;
   logic [XL-1:0]   data_wdata_o;
   logic            data_rvalid_i;
   logic [XL-1:0]   data_rdata_i;
   logic            x_result_valid_i, x_result_ready_o;
   logic [IDW-1:0]  x_result_id_i;
   logic [4:0]      x_result_rd_i;
   logic            x_result_we_i;
   logic [XL-1:0]   x_result_data_i;
   logic            rf_wport_free_i, rf_we_o;
   logic [4:0]      rf_waddr_o;
   logic [XL-1:0]   rf_wdata_o;
   logic            spurious_result_o;

   always #5 clk_i = ~clk_i;

   xif_core_offload_ctrl #(
      .X_ID_WIDTH(IDW), .MAX_OUTSTANDING(MAXO), .XLEN(XL)
   ) dut (
      .clk_i(clk_i), .rst_ni(rst_ni),
      .off_valid_i(off_valid_i), .off_ready_o(off_ready_o), .off_instr_i(off_instr_i),
      .off_rs1_i(off_rs1_i), .off_rs2_i(off_rs2_i),
      .off_resp_valid_o(off_resp_valid_o), .off_resp_accept_o(off_resp_accept_o),
      .off_resp_writeback_o(off_resp_writeback_o), .flush_i(flush_i), .busy_o(busy_o),
      .x_issue_valid_o(x_issue_valid_o), .x_issue_ready_i(x_issue_ready_i),
      .x_issue_instr_o(x_issue_instr_o), .x_issue_id_o(x_issue_id_o),
      .x_issue_rs_o(x_issue_rs_o), .x_issue_rs_valid_o(x_issue_rs_valid_o),
      .x_issue_resp_accept_i(x_issue_resp_accept_i),
      .x_issue_resp_writeback_i(x_issue_resp_writeback_i),
      .x_commit_valid_o(x_commit_valid_o), .x_commit_id_o(x_commit_id_o),
      .x_commit_kill_o(x_commit_kill_o),
      .x_mem_valid_i(x_mem_valid_i), .x_mem_ready_o(x_mem_ready_o), .x_mem_id_i(x_mem_id_i),
      .x_mem_addr_i(x_mem_addr_i), .x_mem_we_i(x_mem_we_i), .x_mem_be_i(x_mem_be_i),
      .x_mem_wdata_i(x_mem_wdata_i), .x_mem_result_valid_o(x_mem_result_valid_o),
      .x_mem_result_id_o(x_mem_result_id_o), .x_mem_result_rdata_o(x_mem_result_rdata_o),
      .data_req_o(data_req_o), .data_gnt_i(data_gnt_i), .data_addr_o(data_addr_o),
      .data_we_o(data_we_o), .data_be_o(data_be_o), .data_wdata_o(data_wdata_o),
      .data_rvalid_i(data_rvalid_i), .data_rdata_i(data_rdata_i),
      .x_result_valid_i(x_result_valid_i), .x_result_ready_o(x_result_ready_o),
      .x_result_id_i(x_result_id_i), .x_result_rd_i(x_result_rd_i),
      .x_result_we_i(x_result_we_i), .x_result_data_i(x_result_data_i),
      .rf_wport_free_i(rf_wport_free_i), .rf_we_o(rf_we_o), .rf_waddr_o(rf_waddr_o),
      .rf_wdata_o(rf_wdata_o), .spurious_result_o(spurious_result_o)
   );

   int errors = 0;
   int checks = 0;

   // Reference model of the offload bookkeeping
   logic [15:0]    m_sb;
   int             m_cnt;
   logic [IDW-1:0] m_next;

   typedef struct packed {logic [IDW-1:0] id; logic kill; logic acc; logic wb;} cmt_t;
   typedef struct packed {logic [4:0] rd; logic [XL-1:0] data;} rf_t;
   typedef struct packed {logic [IDW-1:0] id; logic [XL-1:0] rdata;} mem_t;

   cmt_t cmt_q[$];
   rf_t  rf_q[$];
   mem_t mem_q[$];

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   function automatic logic model_rdy();
      return (m_cnt < MAXO) && !m_sb[m_next];
   endfunction

   task automatic do_issue(input logic [31:0] instr, input logic [XL-1:0] rs1,
                           input logic [XL-1:0] rs2, input logic a, input logic w,
                           input logic fl);
      int   n;
      cmt_t got;
      n = 0;
      off_instr_i = instr;
      off_rs1_i   = rs1;
      off_rs2_i   = rs2;
      off_valid_i = 1'b1;
      while (!off_ready_o && n < 10) begin
         tick();
         n++;
      end
      chk("off_ready_model", off_ready_o, model_rdy());
      chk("off_ready_before_issue", off_ready_o, 1);
      tick();
      off_valid_i = 1'b0;
      chk("issue_valid", x_issue_valid_o, 1);
      chk("issue_id", x_issue_id_o, m_next);
      chk("issue_instr", x_issue_instr_o, instr);
      chk("issue_rs", x_issue_rs_o, {rs2, rs1});
      chk("issue_rs_valid", x_issue_rs_valid_o, 2'b11);
      x_issue_ready_i          = 1'b1;
      x_issue_resp_accept_i    = a;
      x_issue_resp_writeback_i = w;
      flush_i                  = fl;
      cmt_q.push_back('{id: m_next, kill: fl, acc: a, wb: w});
      tick();
      x_issue_ready_i          = 1'b0;
      x_issue_resp_accept_i    = 1'b0;
      x_issue_resp_writeback_i = 1'b0;
      flush_i                  = 1'b0;
      if (a && !fl) begin
         m_sb[m_next] = 1'b1;
         m_cnt++;
      end
      m_next = m_next + 4'd1;
      chk("issue_valid_drop", x_issue_valid_o, 0);
      chk("commit_valid", x_commit_valid_o, 1);
      chk("resp_valid", off_resp_valid_o, 1);
      if (x_commit_valid_o && cmt_q.size() > 0) begin
         got = cmt_q.pop_front();
         chk("commit_id", x_commit_id_o, got.id);
         chk("commit_kill", x_commit_kill_o, got.kill);
         chk("resp_accept", off_resp_accept_o, got.acc);
         chk("resp_writeback", off_resp_writeback_o, got.wb);
      end
      tick();
      chk("commit_pulse_end", x_commit_valid_o, 0);
      chk("resp_pulse_end", off_resp_valid_o, 0);
   endtask

   task automatic do_result(input logic [IDW-1:0] id, input logic [4:0] rd,
                            input logic [XL-1:0] data);
      logic hit;
      rf_t  got;
      hit = m_sb[id];
      x_result_valid_i = 1'b1;
      x_result_id_i    = id;
      x_result_rd_i    = rd;
      x_result_we_i    = 1'b1;
      x_result_data_i  = data;
      rf_wport_free_i  = 1'b1;
      if (hit) rf_q.push_back('{rd: rd, data: data});
      #1;
      chk("result_ready", x_result_ready_o, 1);
      chk("spurious", spurious_result_o, !hit);
      if (rf_q.size() > 0) begin
         got = rf_q.pop_front();
         chk("rf_we", rf_we_o, 1);
         chk("rf_waddr", rf_waddr_o, got.rd);
         chk("rf_wdata", rf_wdata_o, got.data);
      end else begin
         chk("rf_we_blocked", rf_we_o, 0);
      end
      tick();
      x_result_valid_i = 1'b0;
      rf_wport_free_i  = 1'b0;
      if (hit) begin
         m_sb[id] = 1'b0;
         m_cnt--;
      end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int   lat;
      mem_t mg;
      off_valid_i = 0; off_instr_i = 0; off_rs1_i = 0; off_rs2_i = 0; flush_i = 0;
      x_issue_ready_i = 0; x_issue_resp_accept_i = 0; x_issue_resp_writeback_i = 0;
      x_mem_valid_i = 0; x_mem_id_i = 0; x_mem_addr_i = 0; x_mem_we_i = 0;
      x_mem_be_i = 0; x_mem_wdata_i = 0; data_gnt_i = 0; data_rvalid_i = 0;
      data_rdata_i = 0; x_result_valid_i = 0; x_result_id_i = 0; x_result_rd_i = 0;
      x_result_we_i = 0; x_result_data_i = 0; rf_wport_free_i = 0;
      m_sb = '0; m_cnt = 0; m_next = '0;

      // Reset state
      repeat (2) @(posedge clk_i);
      #1;
      chk("rst_off_ready", off_ready_o, 0);
      chk("rst_mem_ready", x_mem_ready_o, 0);
      chk("rst_busy", busy_o, 0);
      chk("rst_issue_valid", x_issue_valid_o, 0);
      chk("rst_data_req", data_req_o, 0);
      rst_ni = 1'b1;
      #1;
      chk("post_rst_off_ready", off_ready_o, 1);
      chk("post_rst_mem_ready", x_mem_ready_o, 1);
      tick();

      // Single accepted offload retired into x5
      do_issue(32'h0000_0053, 32'h3F80_0000, 32'h4000_0000, 1'b1, 1'b1, 1'b0);
      chk("busy_outstanding", busy_o, 1);
      do_result(4'd0, 5'd5, 32'h3F80_0000);
      chk("busy_idle_after_result", busy_o, 0);

      // Rejected offload: commit still emitted, nothing outstanding
      do_issue(32'h1234_5677, 32'h1, 32'h2, 1'b0, 1'b0, 1'b0);
      chk("busy_after_reject", busy_o, 0);

      // Fill to MAX_OUTSTANDING
      for (int i = 0; i < 4; i++)
         do_issue(32'hA000_0000 + i, 32'h100 + i, 32'h200 + i, 1'b1, 1'b1, 1'b0);
      chk("off_ready_full", off_ready_o, 0);
      chk("off_ready_full_model", off_ready_o, model_rdy());
      do_result(4'd3, 5'd7, 32'h1111_2222);
      chk("off_ready_after_free", off_ready_o, 1);
      do_result(4'd3, 5'd7, 32'h3333_4444);

      // Killed offload frees its slot at once; its late result is spurious
      do_issue(32'hB000_0001, 32'h5, 32'h6, 1'b1, 1'b1, 1'b1);
      chk("off_ready_after_kill", off_ready_o, model_rdy());
      do_issue(32'hB000_0002, 32'h7, 32'h8, 1'b1, 1'b0, 1'b0);
      chk("off_ready_full_again", off_ready_o, 0);
      do_result(4'd6, 5'd9, 32'h5555_6666);
      do_result(4'd2, 5'd10, 32'h0000_000A);
      do_result(4'd4, 5'd11, 32'h0000_000B);
      do_result(4'd5, 5'd12, 32'h0000_000C);
      do_result(4'd7, 5'd13, 32'h0000_000D);
      chk("busy_drained", busy_o, 0);

      // Mem load with grant delayed two cycles; second request stalls
      x_mem_valid_i = 1; x_mem_addr_i = 32'h1000; x_mem_we_i = 0;
      x_mem_be_i = 4'hF; x_mem_id_i = 4'd3;
      #1;
      chk("mem_ready_idle", x_mem_ready_o, 1);
      mem_q.push_back('{id: 4'd3, rdata: 32'hDEAD_BEEF});
      tick();
      x_mem_addr_i = 32'h2000; x_mem_we_i = 1; x_mem_wdata_i = 32'h1234_5678;
      x_mem_id_i = 4'd9; x_mem_be_i = 4'h3;
      for (int i = 0; i < 2; i++) begin
         chk("mem_ready_in_req", x_mem_ready_o, 0);
         chk("data_req_no_gnt", data_req_o, 1);
         chk("data_addr_load", data_addr_o, 32'h1000);
         tick();
      end
      chk("data_req_at_gnt", data_req_o, 1);
      data_gnt_i = 1;
      tick();
      data_gnt_i = 0;
      chk("data_req_drop", data_req_o, 0);
      chk("mem_ready_in_wait", x_mem_ready_o, 0);
      tick();
      data_rvalid_i = 1; data_rdata_i = 32'hDEAD_BEEF;
      tick();
      data_rvalid_i = 0; data_rdata_i = 0;
      chk("mem_result_valid", x_mem_result_valid_o, 1);
      chk("mem_ready_in_resp", x_mem_ready_o, 0);
      if (x_mem_result_valid_o && mem_q.size() > 0) begin
         mg = mem_q.pop_front();
         chk("mem_result_id", x_mem_result_id_o, mg.id);
         chk("mem_result_rdata", x_mem_result_rdata_o, mg.rdata);
      end

      // Stalled store proceeds with immediate gnt/rvalid: 3-cycle latency
      data_gnt_i = 1; data_rvalid_i = 1; data_rdata_i = 32'hCAFE_F00D;
      mem_q.push_back('{id: 4'd9, rdata: 32'hCAFE_F00D});
      tick();
      chk("mem_ready_back", x_mem_ready_o, 1);
      tick();
      x_mem_valid_i = 0;
      lat = 1;
      chk("data_req_store", data_req_o, 1);
      chk("data_addr_store", data_addr_o, 32'h2000);
      chk("data_we_store", data_we_o, 1);
      chk("data_be_store", data_be_o, 4'h3);
      chk("data_wdata_store", data_wdata_o, 32'h1234_5678);
      while (!x_mem_result_valid_o && lat < 10) begin
         tick();
         lat++;
      end
      chk("mem_latency", lat, 3);
      if (x_mem_result_valid_o && mem_q.size() > 0) begin
         mg = mem_q.pop_front();
         chk("mem_store_id", x_mem_result_id_o, mg.id);
         chk("mem_store_rdata", x_mem_result_rdata_o, mg.rdata);
      end
      data_gnt_i = 0; data_rvalid_i = 0; data_rdata_i = 0;
      tick();

      // Reset mid-transfer with three outstanding and data_req_o high
      for (int i = 0; i < 3; i++)
         do_issue(32'hC000_0000 + i, 32'h30 + i, 32'h40 + i, 1'b1, 1'b1, 1'b0);
      x_mem_valid_i = 1; x_mem_addr_i = 32'h3000; x_mem_we_i = 0; x_mem_id_i = 4'd1;
      tick();
      x_mem_valid_i = 0;
      chk("pre_rst_data_req", data_req_o, 1);
      chk("pre_rst_busy", busy_o, 1);
      #2;
      rst_ni = 1'b0;
      #1;
      chk("mid_rst_data_req", data_req_o, 0);
      chk("mid_rst_data_addr", data_addr_o, 0);
      chk("mid_rst_off_ready", off_ready_o, 0);
      chk("mid_rst_busy", busy_o, 0);
      chk("mid_rst_mem_ready", x_mem_ready_o, 0);
      chk("mid_rst_commit", x_commit_valid_o, 0);
      rst_ni = 1'b1;
      m_sb = '0; m_cnt = 0; m_next = '0;
      cmt_q.delete(); rf_q.delete(); mem_q.delete();
      tick();
      chk("after_rst_off_ready", off_ready_o, 1);
      do_issue(32'hD000_0000, 32'h9, 32'hA, 1'b1, 1'b1, 1'b0);
      do_result(4'd0, 5'd1, 32'h0BAD_F00D);
      chk("final_busy", busy_o, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
